risc_seq_ctrl: RTL

Multi-cycle sequencing controller for the 16-bit RISC datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the control-flag set for Data Processing, Load, Store, BEQ/BNE and Jump. It also drives the ALU control code, the PC/IR write enables and a request/acknowledge handshake to the shared instruction/data memory. It sits between the instruction register (opcode source) and the register file, ALU, PC mux and memory port.

---
 rtl/risc_seq_ctrl_pkg.sv | 65 ++++++
 rtl/risc_seq_ctrl_alu_decode.sv | 34 +++
 rtl/risc_seq_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/risc_seq_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC sequencing controller.
// Flags, states, opcodes and ALU operation codes.
package gP;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       m2r;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       beq;
    logic       bne;
    logic [1:0] alu_op;
    logic       jmp;
  } ctl_flags_t;

  localparam logic [3:0] OP_LDR = 4'b0000;
  localparam logic [3:0] OP_STR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_INV = 4'b0100;
  localparam logic [3:0] OP_LSL = 4'b0101;
  localparam logic [3:0] OP_LSR = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_HMD = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  localparam logic [1:0] ALUOP_DATA = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_MEM  = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_INV = 4'b0010;
  localparam logic [3:0] ALU_LSL = 4'b0011;
  localparam logic [3:0] ALU_LSR = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_HMD = 4'b1000;

  function automatic logic is_data(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_HMD);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

endpackage

// File: rtl/risc_seq_ctrl_alu_decode.sv
// Combinational ALU control: {alu_op, opcode} -> alu_cnt, zero latency.
// Memory class always adds, branches subtract, data ops select by opcode.
module risc_alu_decode
  import gP::*;
(
  input  logic [1:0] alu_op,
  input  logic [3:0] opcode,
  output logic [3:0] alu_cnt
);

  always_comb begin
    alu_cnt = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: alu_cnt = ALU_ADD;
      ALUOP_BR:  alu_cnt = ALU_SUB;
      ALUOP_DATA: begin
        case (opcode)
          OP_ADD:  alu_cnt = ALU_ADD;
          OP_SUB:  alu_cnt = ALU_SUB;
          OP_INV:  alu_cnt = ALU_INV;
          OP_LSL:  alu_cnt = ALU_LSL;
          OP_LSR:  alu_cnt = ALU_LSR;
          OP_AND:  alu_cnt = ALU_AND;
          OP_OR:   alu_cnt = ALU_OR;
          OP_SLT:  alu_cnt = ALU_SLT;
          OP_HMD:  alu_cnt = ALU_HMD;
          default: alu_cnt = ALU_ADD;
        endcase
      end
      default: alu_cnt = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC datapath.
// Outputs decode from registered state; memory waits stretch FETCH/MEM via mem_ack.
module risc_seq_ctrl
  import gP::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output ctl_flags_t       ctl,
  output logic [3:0]       alu_cnt,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             busy,
  output logic             illegal,
  output logic [WIDTH-1:0] retired
);

  // Assert is immediate through the flop clears; release takes two edges.
  logic [1:0] rst_sync_q;
  logic       core_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign core_rst_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] retired_q, retired_d;
  logic             complete;
  logic             is_beq, is_bne;
  logic [3:0]       dec_cnt;

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    ctl       = '0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    complete  = 1'b0;
    is_beq    = (opcode == OP_BEQ);
    is_bne    = (opcode == OP_BNE);
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_illegal(opcode)) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_data(opcode)) begin
          ctl.alu_op  = ALUOP_DATA;
          ctl.reg_dst = 1'b1;
          state_d     = S_WB;
        end else if (opcode == OP_LDR || opcode == OP_STR) begin
          ctl.alu_op  = ALUOP_MEM;
          ctl.alu_src = 1'b1;
          state_d     = S_MEM;
        end else if (is_beq || is_bne) begin
          ctl.alu_op = ALUOP_BR;
          ctl.beq    = is_beq;
          ctl.bne    = is_bne;
          pc_write   = (is_beq & alu_zero) | (is_bne & ~alu_zero);
          pc_src     = 2'b01;
          complete   = 1'b1;
        end else begin
          ctl.jmp  = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'b10;
          complete = 1'b1;
        end
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_STR) ctl.mem_write = 1'b1;
        else                  ctl.mem_read  = 1'b1;
        if (mem_ack) begin
          if (opcode == OP_STR) complete = 1'b1;
          else                  state_d  = S_WB;
        end
      end
      S_WB: begin
        ctl.reg_write = 1'b1;
        if (opcode == OP_LDR) ctl.m2r     = 1'b1;
        else                  ctl.reg_dst = 1'b1;
        complete = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (complete) state_d = stop ? S_IDLE : S_FETCH;
    retired_d = retired_q + {{(WIDTH-1){1'b0}}, complete};
  end

  risc_alu_decode u_alu_decode (
    .alu_op  (ctl.alu_op),
    .opcode  (opcode),
    .alu_cnt (dec_cnt)
  );

  // Data ops carry alu_op=00 outside EXEC too, so the code is masked there.
  assign alu_cnt = (state_q == S_EXEC) ? dec_cnt : ALU_ADD;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
